if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and the next-PC selection: exception, JR, J, branch or sequential.
- Runs a request/ready handshake with instruction memory and supports wait states.
- Feeds the IF/ID pipeline register, sending it PCPlusBy4, InstrMem_o and Flush_en; honours the hazard unit's stall.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value on reset.
EXC_VECTOR, 32'h0000_0080, PC value on exception redirect.

Ports:
CLK  input  1  clock; all state updates on posedge.
RST  input  1  asynchronous, active-high reset.
PCWrite_en  input  1  from hazard unit; 0 = stall, hold PC and fetched word.
Exception_en  input  1  redirect to EXC_VECTOR.
JR_en  input  1  redirect to JR_target.
JR_target  input  32  register-jump target.
Jump_en  input  1  redirect to Jump_target.
Jump_target  input  32  J/JAL target.
Branch_taken  input  1  redirect to Branch_target.
Branch_target  input  32  resolved branch target.
Imem_ready  input  1  instruction memory has Imem_rdata valid for Imem_addr this cycle.
Imem_rdata  input  32  instruction word.
Imem_req  output  1  fetch request.
Imem_addr  output  32  fetch address (= PC).
PC  output  32  current fetch PC.
PCPlusBy4  output  32  PC+4 of the delivered instruction; goes to the IF/ID register.
InstrMem_o  output  32  delivered instruction; 0 (NOP) when Fetch_valid=0.
Fetch_valid  output  1  InstrMem_o holds a real instruction this cycle.
Flush_en  output  1  combinational; 1 in any cycle with a redirect, so IF/ID zeroes its instruction.

Behaviour:
- Redirect = Exception_en | JR_en | Jump_en | Branch_taken.
  - Priority: Exception > JR > Jump > Branch.
  - The selected target has bits [1:0] forced to 0.
  - Redirect overrides PCWrite_en: a stall never blocks a redirect.
- PC+4 arithmetic is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- States: FETCH, HOLD, DRAIN. Reset state is FETCH.
- Reset (async):
  - PC = RESET_VECTOR; holding buffer = 0; redirect_pc = 0; state = FETCH.
  - While RST=1: Imem_req=0, Fetch_valid=0, InstrMem_o=0, Flush_en=0.
  - A mid-access reset abandons the access; any late Imem_ready is ignored until Imem_req is asserted again.
- FETCH:
  - Imem_req=1 and Imem_addr=PC, held stable until Imem_ready.
  - Imem_ready=1 and redirect: data is squashed (Fetch_valid=0); PC <= target; stay in FETCH.
  - Imem_ready=1, no redirect, PCWrite_en=1: Fetch_valid=1, InstrMem_o=Imem_rdata, PCPlusBy4=PC+4; PC <= PC+4; stay in FETCH. Gives back-to-back fetch with zero-wait memory.
  - Imem_ready=1, no redirect, PCWrite_en=0: buffer <= Imem_rdata; go to HOLD; PC unchanged; Fetch_valid=0.
  - Imem_ready=0 and redirect: redirect_pc <= target; go to DRAIN.
  - Imem_ready=0, no redirect: Fetch_valid=0; wait.
- HOLD:
  - Imem_req=0.
  - PCWrite_en=1, no redirect: Fetch_valid=1, InstrMem_o=buffer, PCPlusBy4=PC+4; PC <= PC+4; go to FETCH.
  - Redirect: buffer is discarded; PC <= target; go to FETCH.
  - Otherwise: stay in HOLD with Fetch_valid=0.
- DRAIN:
  - Imem_req=1 with Imem_addr = old PC, since the outstanding access must complete.
  - Fetch_valid=0.
  - Further redirects overwrite redirect_pc (newest wins); Flush_en is still asserted.
  - On Imem_ready: data discarded; PC <= redirect_pc (or the new target if a redirect is present that cycle); go to FETCH.
- Outputs when Fetch_valid=0: InstrMem_o=0 and PCPlusBy4=PC+4.

Test Plan:
- Reset then zero-wait memory (Imem_ready=1), PCWrite_en=1: Imem_addr goes 0x0, 0x4, 0x8 in consecutive cycles; Fetch_valid=1 each cycle; PCPlusBy4 = 0x4, 0x8, 0xC.
- Stall: fetch at PC=0x10 with PCWrite_en=0 for 3 cycles → state HOLD, Imem_req=0, PC stays 0x10, Fetch_valid=0. Release → InstrMem_o = the buffered word, PCPlusBy4=0x14, next Imem_addr=0x14.
- Simultaneous Exception_en, JR_en (JR_target=0x400), Branch_taken (Branch_target=0x200) at PC=0x20 → Flush_en=1, next PC=0x80, no Fetch_valid that cycle.
- Redirect during a wait state: Imem_ready=0 for 2 cycles, Jump_en with Jump_target=0x1003 on cycle 1 → Imem_addr holds the old PC, then data is discarded and the next Imem_addr=0x1000.
- Wrap-around: PC=0xFFFF_FFFC fetched with PCWrite_en=1 → PCPlusBy4=0x0 and next PC=0x0.
- RST pulsed mid-DRAIN → Imem_req=0 immediately (asynchronous); after release PC=0x0, state FETCH; a stale Imem_ready pulse during reset is ignored.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, picks the next PC and runs the
// request/ready handshake with instruction memory, including wait states and stalls.
module if_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCWrite_en,
    input  logic        Exception_en,
    input  logic        JR_en,
    input  logic [31:0] JR_target,
    input  logic        Jump_en,
    input  logic [31:0] Jump_target,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic        Imem_ready,
    input  logic [31:0] Imem_rdata,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    output logic [31:0] PC,
    output logic [31:0] PCPlusBy4,
    output logic [31:0] InstrMem_o,
    output logic        Fetch_valid,
    output logic        Flush_en
);

    typedef enum logic [1:0] {StFetch, StHold, StDrain} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign redirect = Exception_en | JR_en | Jump_en | Branch_taken;

    always_comb begin
        target_raw = Branch_target;
        if (Exception_en) begin
            target_raw = EXC_VECTOR;
        end else if (JR_en) begin
            target_raw = JR_target;
        end else if (Jump_en) begin
            target_raw = Jump_target;
        end
    end

    assign target    = {target_raw[31:2], 2'b00};
    assign pc_plus4  = pc_q + 32'd4;
    assign PC        = pc_q;
    assign Imem_addr = pc_q;
    assign PCPlusBy4 = pc_plus4;
    assign Flush_en  = redirect & ~RST;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        redirect_pc_d = redirect_pc_q;
        Imem_req      = 1'b0;
        Fetch_valid   = 1'b0;
        InstrMem_o    = '0;
        unique case (state_q)
            StFetch: begin
                Imem_req = 1'b1;
                if (Imem_ready) begin
                    if (redirect) begin
                        pc_d = target;
                    end else if (PCWrite_en) begin
                        Fetch_valid = 1'b1;
                        InstrMem_o  = Imem_rdata;
                        pc_d        = pc_plus4;
                    end else begin
                        buf_d   = Imem_rdata;
                        state_d = StHold;
                    end
                end else if (redirect) begin
                    // Access already in flight: remember where to go once it completes.
                    redirect_pc_d = target;
                    state_d       = StDrain;
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = StFetch;
                end else if (PCWrite_en) begin
                    Fetch_valid = 1'b1;
                    InstrMem_o  = buf_q;
                    pc_d        = pc_plus4;
                    state_d     = StFetch;
                end
            end
            StDrain: begin
                Imem_req = 1'b1;
                if (Imem_ready) begin
                    pc_d    = redirect ? target : redirect_pc_q;
                    state_d = StFetch;
                end else if (redirect) begin
                    redirect_pc_d = target;
                end
            end
            default: state_d = StFetch;
        endcase
        if (RST) begin
            Imem_req    = 1'b0;
            Fetch_valid = 1'b0;
            InstrMem_o  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= StFetch;
            pc_q          <= RESET_VECTOR;
            buf_q         <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_q         <= buf_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized run
// compared against a behavioural model of the fetch rules.
module tb_if_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        PCWrite_en;
    logic        Exception_en;
    logic        JR_en;
    logic [31:0] JR_target;
    logic        Jump_en;
    logic [31:0] Jump_target;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic        Imem_ready;
    logic [31:0] Imem_rdata;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic [31:0] PC;
    logic [31:0] PCPlusBy4;
    logic [31:0] InstrMem_o;
    logic        Fetch_valid;
    logic        Flush_en;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: PC, a captured word awaiting release, and a pending redirect.
    logic [31:0] m_pc;
    logic        m_have_buf;
    logic [31:0] m_buf;
    logic        m_pending;
    logic [31:0] m_pend;

    if_fetch_unit dut (
        .CLK          (CLK),
        .RST          (RST),
        .PCWrite_en   (PCWrite_en),
        .Exception_en (Exception_en),
        .JR_en        (JR_en),
        .JR_target    (JR_target),
        .Jump_en      (Jump_en),
        .Jump_target  (Jump_target),
        .Branch_taken (Branch_taken),
        .Branch_target(Branch_target),
        .Imem_ready   (Imem_ready),
        .Imem_rdata   (Imem_rdata),
        .Imem_req     (Imem_req),
        .Imem_addr    (Imem_addr),
        .PC           (PC),
        .PCPlusBy4    (PCPlusBy4),
        .InstrMem_o   (InstrMem_o),
        .Fetch_valid  (Fetch_valid),
        .Flush_en     (Flush_en)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        if (Exception_en)      t = 32'h0000_0080;
        else if (JR_en)        t = JR_target;
        else if (Jump_en)      t = Jump_target;
        else                   t = Branch_target;
        return t - (t % 4);
    endfunction

    task automatic no_redirect();
        Exception_en = 1'b0;
        JR_en        = 1'b0;
        Jump_en      = 1'b0;
        Branch_taken = 1'b0;
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        no_redirect();
        Imem_ready = 1'b0;
        PCWrite_en = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST          = 1'b1;
        PCWrite_en   = 1'b1;
        Imem_ready   = 1'b1;
        Imem_rdata   = 32'hDEAD_BEEF;
        JR_target    = 32'h0;
        Jump_target  = 32'h0;
        Branch_target = 32'h0;
        no_redirect();
        Jump_en = 1'b1;
        @(negedge CLK);
        #1;
        n_tests++;
        if (Imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b expected 0", Imem_req);
        end
        n_tests++;
        if (Fetch_valid !== 1'b0 || InstrMem_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_valid: got %b/%h expected 0/0", Fetch_valid, InstrMem_o);
        end
        n_tests++;
        if (Flush_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_flush: got %b expected 0", Flush_en);
        end
        n_tests++;
        if (PC !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h expected 00000000", PC);
        end
        @(negedge CLK);
        Jump_en = 1'b0;
        RST     = 1'b0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] w;
        Imem_ready = 1'b1;
        PCWrite_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            Imem_rdata = w;
            #1;
            n_tests++;
            if (Imem_addr !== 32'(4 * i) || Imem_req !== 1'b1) begin
                n_fail++; $display("FAIL zw_addr%0d: got %h/%b expected %h/1", i, Imem_addr, Imem_req, 4 * i);
            end
            n_tests++;
            if (Fetch_valid !== 1'b1 || InstrMem_o !== w || PCPlusBy4 !== 32'(4 * i + 4)) begin
                n_fail++; $display("FAIL zw_deliver%0d: got %b/%h/%h expected 1/%h/%h",
                                   i, Fetch_valid, InstrMem_o, PCPlusBy4, w, 4 * i + 4);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        Imem_ready = 1'b1;
        PCWrite_en = 1'b1;
        @(negedge CLK);  // 0xC -> 0x10
        w = $urandom;
        Imem_rdata = w;
        PCWrite_en = 1'b0;
        #1;
        n_tests++;
        if (Imem_addr !== 32'h10 || Fetch_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_capture: got %h/%b expected 00000010/0", Imem_addr, Fetch_valid);
        end
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            Imem_ready = 1'($urandom);
            Imem_rdata = $urandom;
            #1;
            n_tests++;
            if (Imem_req !== 1'b0 || PC !== 32'h10 || Fetch_valid !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: got %b/%h/%b expected 0/00000010/0",
                                   i, Imem_req, PC, Fetch_valid);
            end
            @(negedge CLK);
        end
        Imem_ready = 1'b0;
        PCWrite_en = 1'b1;
        #1;
        n_tests++;
        if (Fetch_valid !== 1'b1 || InstrMem_o !== w || PCPlusBy4 !== 32'h14) begin
            n_fail++; $display("FAIL stall_release: got %b/%h/%h expected 1/%h/00000014",
                               Fetch_valid, InstrMem_o, PCPlusBy4, w);
        end
        @(negedge CLK);
        #1;
        n_tests++;
        if (Imem_addr !== 32'h14 || Imem_req !== 1'b1) begin
            n_fail++; $display("FAIL stall_next: got %h/%b expected 00000014/1", Imem_addr, Imem_req);
        end
    endtask

    task automatic redirect_cycle(input string name, input logic [31:0] exp_pc);
        Imem_ready = 1'b1;
        Imem_rdata = $urandom;
        #1;
        n_tests++;
        if (Flush_en !== 1'b1 || Fetch_valid !== 1'b0 || InstrMem_o !== 32'h0) begin
            n_fail++; $display("FAIL %s_flush: got %b/%b/%h expected 1/0/0", name, Flush_en, Fetch_valid, InstrMem_o);
        end
        @(negedge CLK);
        no_redirect();
        #1;
        n_tests++;
        if (PC !== exp_pc) begin
            n_fail++; $display("FAIL %s_pc: got %h expected %h", name, PC, exp_pc);
        end
    endtask

    task automatic test_priority();
        PCWrite_en  = 1'b1;
        Jump_en     = 1'b1;
        Jump_target = 32'h22;
        redirect_cycle("jump_mask", 32'h20);
        Exception_en  = 1'b1;
        JR_en         = 1'b1;
        JR_target     = 32'h400;
        Branch_taken  = 1'b1;
        Branch_target = 32'h200;
        PCWrite_en    = 1'b0;
        redirect_cycle("exc_prio", 32'h80);
        JR_en         = 1'b1;
        JR_target     = 32'h401;
        Jump_en       = 1'b1;
        Jump_target   = 32'h300;
        Branch_taken  = 1'b1;
        redirect_cycle("jr_prio", 32'h400);
        Jump_en       = 1'b1;
        Branch_taken  = 1'b1;
        redirect_cycle("jump_prio", 32'h300);
        Branch_taken  = 1'b1;
        Branch_target = 32'h202;
        redirect_cycle("branch", 32'h200);
        PCWrite_en = 1'b1;
    endtask

    task automatic test_drain();
        Imem_ready  = 1'b0;
        Jump_en     = 1'b1;
        Jump_target = 32'h1003;
        #1;
        n_tests++;
        if (Flush_en !== 1'b1 || Imem_addr !== 32'h200 || Imem_req !== 1'b1 || Fetch_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_start: got %b/%h/%b/%b expected 1/00000200/1/0",
                               Flush_en, Imem_addr, Imem_req, Fetch_valid);
        end
        @(negedge CLK);
        no_redirect();
        #1;
        n_tests++;
        if (Imem_req !== 1'b1 || Imem_addr !== 32'h200 || Fetch_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_wait: got %b/%h/%b expected 1/00000200/0", Imem_req, Imem_addr, Fetch_valid);
        end
        @(negedge CLK);
        Imem_ready = 1'b1;
        Imem_rdata = $urandom;
        #1;
        n_tests++;
        if (Fetch_valid !== 1'b0 || InstrMem_o !== 32'h0) begin
            n_fail++; $display("FAIL drain_discard: got %b/%h expected 0/0", Fetch_valid, InstrMem_o);
        end
        @(negedge CLK);
        #1;
        n_tests++;
        if (Imem_addr !== 32'h1000) begin
            n_fail++; $display("FAIL drain_target: got %h expected 00001000", Imem_addr);
        end
        // Newest redirect while draining wins.
        Imem_ready = 1'b0;
        JR_en      = 1'b1;
        JR_target  = 32'h2000;
        @(negedge CLK);
        no_redirect();
        Branch_taken  = 1'b1;
        Branch_target = 32'h3000;
        #1;
        n_tests++;
        if (Flush_en !== 1'b1 || Imem_addr !== 32'h1000) begin
            n_fail++; $display("FAIL drain_flush2: got %b/%h expected 1/00001000", Flush_en, Imem_addr);
        end
        @(negedge CLK);
        no_redirect();
        Imem_ready = 1'b1;
        @(negedge CLK);
        #1;
        n_tests++;
        if (PC !== 32'h3000) begin
            n_fail++; $display("FAIL drain_newest: got %h expected 00003000", PC);
        end
        // Redirect arriving in the completion cycle takes precedence.
        Imem_ready  = 1'b0;
        Jump_en     = 1'b1;
        Jump_target = 32'h4000;
        @(negedge CLK);
        no_redirect();
        Imem_ready    = 1'b1;
        Branch_taken  = 1'b1;
        Branch_target = 32'h5000;
        @(negedge CLK);
        no_redirect();
        #1;
        n_tests++;
        if (PC !== 32'h5000) begin
            n_fail++; $display("FAIL drain_late: got %h expected 00005000", PC);
        end
    endtask

    task automatic test_wrap();
        Imem_ready  = 1'b1;
        PCWrite_en  = 1'b1;
        Jump_en     = 1'b1;
        Jump_target = 32'hFFFF_FFFF;
        @(negedge CLK);
        no_redirect();
        Imem_rdata = $urandom;
        #1;
        n_tests++;
        if (PC !== 32'hFFFF_FFFC || PCPlusBy4 !== 32'h0 || Fetch_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_plus4: got %h/%h/%b expected fffffffc/00000000/1", PC, PCPlusBy4, Fetch_valid);
        end
        @(negedge CLK);
        #1;
        n_tests++;
        if (PC !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pc: got %h expected 00000000", PC);
        end
    endtask

    task automatic test_reset_mid_drain();
        Imem_ready  = 1'b0;
        Jump_en     = 1'b1;
        Jump_target = 32'h600;
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        n_tests++;
        if (Imem_req !== 1'b0 || PC !== 32'h0 || Flush_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: got %b/%h/%b expected 0/00000000/0", Imem_req, PC, Flush_en);
        end
        Imem_ready = 1'b1;  // stale response during reset
        Imem_rdata = $urandom;
        @(negedge CLK);
        no_redirect();
        #1;
        n_tests++;
        if (Imem_req !== 1'b0 || Fetch_valid !== 1'b0 || InstrMem_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_held: got %b/%b/%h expected 0/0/0", Imem_req, Fetch_valid, InstrMem_o);
        end
        RST        = 1'b0;
        Imem_ready = 1'b0;
        #1;
        n_tests++;
        if (Imem_req !== 1'b1 || Imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_release: got %b/%h expected 1/00000000", Imem_req, Imem_addr);
        end
        @(negedge CLK);
        Imem_ready = 1'b1;
        PCWrite_en = 1'b1;
        Imem_rdata = $urandom;
        #1;
        n_tests++;
        if (Fetch_valid !== 1'b1 || PC !== 32'h0) begin
            n_fail++; $display("FAIL rst_fetch: got %b/%h expected 1/00000000", Fetch_valid, PC);
        end
        @(negedge CLK);
        #1;
        n_tests++;
        if (PC !== 32'h4) begin
            n_fail++; $display("FAIL rst_next: got %h expected 00000004", PC);
        end
    endtask

    task automatic test_random();
        logic        redir;
        logic [31:0] tgt;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_instr;
        apply_reset();
        m_pc       = 32'h0;
        m_have_buf = 1'b0;
        m_buf      = 32'h0;
        m_pending  = 1'b0;
        m_pend     = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            Exception_en  = ($urandom_range(0, 31) == 0);
            JR_en         = ($urandom_range(0, 15) == 0);
            Jump_en       = ($urandom_range(0, 15) == 0);
            Branch_taken  = ($urandom_range(0, 11) == 0);
            JR_target     = $urandom;
            Jump_target   = $urandom;
            Branch_target = $urandom;
            Imem_ready    = ($urandom_range(0, 3) != 0);
            PCWrite_en    = ($urandom_range(0, 3) != 0);
            Imem_rdata    = $urandom;
            #1;
            redir   = Exception_en || JR_en || Jump_en || Branch_taken;
            tgt     = pick_target();
            e_req   = !m_have_buf;
            e_valid = 1'b0;
            e_instr = 32'h0;
            if (m_have_buf) begin
                if (!redir && PCWrite_en) begin
                    e_valid = 1'b1;
                    e_instr = m_buf;
                end
            end else if (!m_pending && Imem_ready && !redir && PCWrite_en) begin
                e_valid = 1'b1;
                e_instr = Imem_rdata;
            end
            n_tests++;
            if (PC !== m_pc || Imem_addr !== m_pc || PCPlusBy4 !== m_pc + 32'd4) begin
                n_fail++; $display("FAIL rnd_pc@%0d: got %h/%h/%h expected %h/%h/%h",
                                   c, PC, Imem_addr, PCPlusBy4, m_pc, m_pc, m_pc + 32'd4);
            end
            n_tests++;
            if (Imem_req !== e_req || Flush_en !== redir) begin
                n_fail++; $display("FAIL rnd_ctl@%0d: got req %b flush %b expected %b %b",
                                   c, Imem_req, Flush_en, e_req, redir);
            end
            n_tests++;
            if (Fetch_valid !== e_valid || InstrMem_o !== e_instr) begin
                n_fail++; $display("FAIL rnd_data@%0d: got %b/%h expected %b/%h",
                                   c, Fetch_valid, InstrMem_o, e_valid, e_instr);
            end
            if (m_have_buf) begin
                if (redir) begin
                    m_pc = tgt; m_have_buf = 1'b0;
                end else if (PCWrite_en) begin
                    m_pc = m_pc + 32'd4; m_have_buf = 1'b0;
                end
            end else if (m_pending) begin
                if (Imem_ready) begin
                    m_pc = redir ? tgt : m_pend; m_pending = 1'b0;
                end else if (redir) begin
                    m_pend = tgt;
                end
            end else if (Imem_ready) begin
                if (redir)           m_pc = tgt;
                else if (PCWrite_en) m_pc = m_pc + 32'd4;
                else begin
                    m_buf = Imem_rdata; m_have_buf = 1'b1;
                end
            end else if (redir) begin
                m_pending = 1'b1; m_pend = tgt;
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_priority();
        test_drain();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
